// File: rtl/multiplier_4bit_pkg.sv
// Shared constants and types for the 4x4 unsigned array multiplier.
// Defines the operand and product widths, plus the latency constant MULT_LAT.
// MULT_LAT follows the MULTIPLIER_4BIT_PIPE_EN build option: 2 when it is defined, 1 otherwise.
package multiplier_4bit_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

`ifdef MULTIPLIER_4BIT_PIPE_EN
  localparam int MULT_LAT = 2;
`else
  localparam int MULT_LAT = 1;
`endif

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mult4_adder_row.sv
// One row of the array multiplier: a 4-bit ripple-carry chain of full adders.
// Ports: x_i/y_i are the addends, cin_i is the carry-in, sum_o is the 4-bit sum,
//        cout_o is the carry out of the top bit.
// The row is purely combinational, so it adds no latency and has no backpressure.
module mult4_adder_row
  import multiplier_4bit_pkg::*;
(
  input  logic [OP_W-1:0] x_i,
  input  logic [OP_W-1:0] y_i,
  input  logic            cin_i,
  output logic [OP_W-1:0] sum_o,
  output logic            cout_o
);

  logic carry;

  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int k = 0; k < OP_W; k++) begin
      sum_o[k] = x_i[k] ^ y_i[k] ^ carry;
      carry    = (x_i[k] & y_i[k]) | (carry & (x_i[k] ^ y_i[k]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/multiplier_4bit.sv
// Unsigned 4x4 -> 8-bit array multiplier with a registered product and a valid flag.
// Ports: clk/rst (async active-high); a, b, in_valid in; p, out_valid out.
// Latency is MULT_LAT cycles: 1 by default, 2 with MULTIPLIER_4BIT_PIPE_EN. Throughput is 1/cycle and there is no backpressure.
// p tracks a*b of the inputs on every cycle; out_valid is the only qualifier.
module multiplier_4bit
  import multiplier_4bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              in_valid,
  output logic [PROD_W-1:0] p,
  output logic              out_valid
);

  // Partial products: pp[i][j] = a[j] & b[i]
  logic [OP_W-1:0] pp [OP_W];

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = a & {OP_W{b[i]}};
    end
  end

  // Row 1 adds pp[1] to the upper bits of pp[0]; its LSB is product bit 1.
  logic [OP_W-1:0] s1, s2, s3;
  logic            c1, c2, c3;
  logic [OP_W-1:0] acc1_d;
  logic [1:0]      plo_d;

  mult4_adder_row u_row1 (
    .x_i    (pp[1]),
    .y_i    ({1'b0, pp[0][OP_W-1:1]}),
    .cin_i  (1'b0),
    .sum_o  (s1),
    .cout_o (c1)
  );

  // Carry out of row 1 becomes the top bit of the running sum for row 2.
  assign acc1_d = {c1, s1[OP_W-1:1]};
  assign plo_d  = {s1[0], pp[0][0]};

  // Operands seen by the final two rows; they come from the stage-1 register when pipelined.
  logic [OP_W-1:0] row2_pp, row3_pp, row2_acc;
  logic [1:0]      plo_s2;
  logic            vld_s2;

`ifdef MULTIPLIER_4BIT_PIPE_EN
  logic [OP_W-1:0] acc1_q, pp2_q, pp3_q;
  logic [1:0]      plo_q;
  logic            vld1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1_q <= '0;
      pp2_q  <= '0;
      pp3_q  <= '0;
      plo_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      acc1_q <= acc1_d;
      pp2_q  <= pp[2];
      pp3_q  <= pp[3];
      plo_q  <= plo_d;
      vld1_q <= in_valid;
    end
  end

  assign row2_pp  = pp2_q;
  assign row3_pp  = pp3_q;
  assign row2_acc = acc1_q;
  assign plo_s2   = plo_q;
  assign vld_s2   = vld1_q;
`else
  assign row2_pp  = pp[2];
  assign row3_pp  = pp[3];
  assign row2_acc = acc1_d;
  assign plo_s2   = plo_d;
  assign vld_s2   = in_valid;
`endif

  mult4_adder_row u_row2 (
    .x_i    (row2_pp),
    .y_i    (row2_acc),
    .cin_i  (1'b0),
    .sum_o  (s2),
    .cout_o (c2)
  );

  mult4_adder_row u_row3 (
    .x_i    (row3_pp),
    .y_i    ({c2, s2[OP_W-1:1]}),
    .cin_i  (1'b0),
    .sum_o  (s3),
    .cout_o (c3)
  );

  // Output register
  logic [PROD_W-1:0] p_d, p_q;
  logic              vld_d, vld_q;

  assign p_d   = {c3, s3, s2[0], plo_s2};
  assign vld_d = vld_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      vld_q <= vld_d;
    end
  end

  assign p         = p_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_multiplier_4bit.sv
module tb_multiplier_4bit;
  import multiplier_4bit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  op_t         a = '0;
  op_t         b = '0;
  logic        in_valid = 1'b0;
  prod_t       p;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  prod_t exp_q[$];

  // Reference delay line for out_valid and for the product seen on every cycle.
  logic  vpipe [MULT_LAT];
  prod_t ppipe [MULT_LAT];

  typedef struct {
    op_t   a;
    op_t   b;
    logic  v;
    prod_t exp;
  } vec_t;

  vec_t vecs [12];

  multiplier_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .p         (p),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MULT_LAT; k++) begin
        vpipe[k] <= 1'b0;
        ppipe[k] <= '0;
      end
    end else begin
      for (int k = MULT_LAT - 1; k > 0; k--) begin
        vpipe[k] <= vpipe[k-1];
        ppipe[k] <= ppipe[k-1];
      end
      vpipe[0] <= in_valid;
      ppipe[0] <= prod_t'(int'(a) * int'(b));
    end
  end

  // Scoreboard: compare at the falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_valid !== vpipe[MULT_LAT-1]) begin
        errors++;
        $display("FAIL out_valid_timing: got %b, expected %b at %0t", out_valid, vpipe[MULT_LAT-1], $time);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: p=%0d with no pending product at %0t", p, $time);
        end else begin
          prod_t e;
          e = exp_q.pop_front();
          if (p !== e) begin
            errors++;
            $display("FAIL product: got %0d, expected %0d at %0t", p, e, $time);
          end
        end
      end else begin
        checks++;
        if (p !== ppipe[MULT_LAT-1]) begin
          errors++;
          $display("FAIL invalid_cycle_p: got %0d, expected %0d at %0t", p, ppipe[MULT_LAT-1], $time);
        end
      end
    end
  end

  // Drive one input cycle; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input op_t ta, input op_t tb, input logic tv, input prod_t texp);
    a        = ta;
    b        = tb;
    in_valid = tv;
    if (tv) exp_q.push_back(texp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('0, '0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (p !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: p=%0d out_valid=%b, expected p=0 out_valid=0", tag, p, out_valid);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected products never appeared", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{a: 4'd0,  b: 4'd13, v: 1'b1, exp: 8'd0};
    vecs[1]  = '{a: 4'd13, b: 4'd0,  v: 1'b1, exp: 8'd0};
    vecs[2]  = '{a: 4'd1,  b: 4'd11, v: 1'b1, exp: 8'd11};
    vecs[3]  = '{a: 4'd8,  b: 4'd8,  v: 1'b1, exp: 8'h40};
    vecs[4]  = '{a: 4'd3,  b: 4'd5,  v: 1'b1, exp: 8'd15};
    vecs[5]  = '{a: 4'd7,  b: 4'd9,  v: 1'b1, exp: 8'd63};
    vecs[6]  = '{a: 4'd2,  b: 4'd3,  v: 1'b1, exp: 8'd6};
    vecs[7]  = '{a: 4'd4,  b: 4'd4,  v: 1'b0, exp: 8'd16};
    vecs[8]  = '{a: 4'd5,  b: 4'd6,  v: 1'b1, exp: 8'd30};
    vecs[9]  = '{a: 4'd15, b: 4'd1,  v: 1'b1, exp: 8'd15};
    vecs[10] = '{a: 4'd12, b: 4'd13, v: 1'b1, exp: 8'd156};
    vecs[11] = '{a: 4'd14, b: 4'd11, v: 1'b1, exp: 8'd154};

    // Reset state with no clock edge yet
    #1;
    check_reset_state("reset_no_clock");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_reset_state("reset_held");
    rst = 1'b0;

    // Table: zero/identity, valid gating, back-to-back pipeline pair
    for (int i = 0; i < 12; i++) drive(vecs[i].a, vecs[i].b, vecs[i].v, vecs[i].exp);
    idle(MULT_LAT + 1);
    check_drained("table_drain");

    // Exhaustive sweep, valid every cycle
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(op_t'(i), op_t'(j), 1'b1, prod_t'(i * j));
      end
    end
    idle(MULT_LAT + 1);
    check_drained("sweep_drain");

    // Async reset between edges with 15*15 in flight
    drive(4'd15, 4'd15, 1'b1, 8'd225);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset_immediate");
    exp_q.delete();
    @(posedge clk);
    #1;
    check_reset_state("async_reset_clocked");
    rst = 1'b0;
    drive(4'd9, 4'd9, 1'b1, 8'd81);
    idle(MULT_LAT + 1);
    check_drained("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
